alu: RTL and testbench
======================

# alu

32-bit registered arithmetic/logic unit for the mini processor datapath. It takes two operands from the bus-side operand registers and a 4-bit opcode from the decoder. It produces a registered 32-bit result plus NZCV status flags one clock after the inputs are sampled. It is purely datapath: no handshake and no internal state beyond the output registers.

## Interface
- No parameters; datapath width fixed at 32 bits.
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  reset, synchronous and active-low.
- a  input  32  operand A.
- b  input  32  operand B; for shifts, b[4:0] is the shift amount.
- op  input  4  operation select.
- ALU_result  output  32  registered result.
- flag_n  output  1  registered: ALU_result[31].
- flag_z  output  1  registered: ALU_result == 0.
- flag_c  output  1  registered carry (per-op rules below).
- flag_v  output  1  registered signed overflow (ADD/SUB only).

## Operation
- 4'h0 NOP: result 32'h0.
- 4'h1 NOT: ~a.
- 4'h2 AND: a & b.
- 4'h3 OR: a | b.
- 4'h4 XOR: a ^ b.
- 4'h5 XNOR: ~(a ^ b).
- 4'h6 ADD: a + b mod 2^32.
  - C = bit 32 of the 33-bit sum.
  - V = a[31]==b[31] && sum[31]!=a[31].
- 4'h7 SUB: a − b mod 2^32, computed as a + ~b + 1.
  - C = 1 when no borrow (a >= b unsigned).
  - V = a[31]!=b[31] && diff[31]!=a[31].
- 4'h8 LSL, 4'h9 LSR, 4'hA ASR, 4'hB ROR: a shifted or rotated by b[4:0].
  - b[31:5] is ignored.
  - C = last bit shifted out; C = 0 when the amount is 0.
  - For ROR, C = result[31] when the amount is nonzero.
- 4'hC–4'hF reserved: result 0, all flags per the result (Z=1, N=0, C=0, V=0).
- C and V are 0 for every op that does not define them. N and Z are always derived from the registered result.
- Signedness matters only for V and ASR. All other ops are bitwise or modular.

## Timing
- A single register stage. Inputs sampled at rising clk edge k appear on ALU_result/flags after edge k, stable for the whole cycle k+1. Latency 1, throughput 1 op per cycle.
- Outputs update every cycle; there is no enable or hold. Changing op or operands every cycle is legal.
- Reset: when reset_n==0 at a rising edge, the outputs become ALU_result=0, flag_n=0, flag_z=1, flag_c=0, flag_v=0, regardless of a/b/op.
- Reset asserted mid-stream discards the op sampled on that edge. The first valid result appears one cycle after the first edge with reset_n==1.
- No combinational path from inputs to outputs.

## Configuration
- ALU_SHIFT_EN defined: opcodes 4'h8–4'hB implement LSL/LSR/ASR/ROR as above.
- ALU_SHIFT_EN undefined: the shifter is not built. Opcodes 4'h8–4'hB behave as reserved: result 0, Z=1, N=C=V=0.
- Opcodes 0–7 are identical in both builds.

## Test plan
- Reset: hold reset_n=0 with a=32'hFFFFFFFF, b=1, op=6 → ALU_result=0, Z=1, N=C=V=0. Release reset → the next cycle gives 0, C=1, Z=1.
- Logic ops, each checked one cycle later:
  - NOT a=3 → 32'hFFFFFFFC, N=1.
  - a=5, b=9 AND → 1.
  - a=5, b=A OR → F.
  - a=3, b=5 XOR → 6.
  - a=3, b=5 XNOR → 32'hFFFFFFF9.
  - NOP → 0, Z=1.
- ADD:
  - 0+0 → 0, Z=1.
  - 32'hFFFFFFFF+F → 32'hE, C=1.
  - A+3 → D.
  - 7FFFFFFF+1 → 80000000, V=1, N=1.
- SUB:
  - F−5 → A, C=1.
  - 5−7 → FFFFFFFE, C=0, N=1.
  - A−A → 0, Z=1, C=1.
  - 80000000−1 → 7FFFFFFF, V=1.
- Shifts (ALU_SHIFT_EN defined):
  - a=80000001, b=1: LSL → 2, C=1.
  - LSR → 40000000, C=1.
  - ASR → C0000000, C=1.
  - ROR → C0000000.
  - Amount b=32 → treated as 0: result = a, C=0.
  - With ALU_SHIFT_EN undefined → all four give 0, Z=1.
- Back-to-back: change op every cycle across 0–7 with fixed a=3, b=5. Each result lags its op by exactly one cycle with no bubbles. Reserved op 4'hF → 0.

Source files
------------

// File: rtl/alu.sv
// 32-bit registered ALU with NZCV flags, one cycle latency.
// Shifter (LSL/LSR/ASR/ROR on 8-B) is built only when ALU_SHIFT_EN is defined.
module alu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] ALU_result,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v
);

  logic [32:0] w_sum;
  logic [31:0] w_res;
  logic        w_c;
  logic        w_v;

`ifdef ALU_SHIFT_EN
  logic [4:0]  w_amt;
  logic [32:0] w_lsl;
  logic [32:0] w_lsr;
  logic [32:0] w_asr;
  logic [31:0] w_ror;

  // Extra guard bit catches the last bit shifted out; it stays 0 for amt 0.
  assign w_amt = b[4:0];
  assign w_lsl = {1'b0, a} << w_amt;
  assign w_lsr = {a, 1'b0} >> w_amt;
  assign w_asr = $signed({a, 1'b0}) >>> w_amt;
  assign w_ror = 32'({a, a} >> w_amt);
`endif

  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      4'h1: w_res = ~a;
      4'h2: w_res = a & b;
      4'h3: w_res = a | b;
      4'h4: w_res = a ^ b;
      4'h5: w_res = ~(a ^ b);
      4'h6: begin
        w_sum = {1'b0, a} + {1'b0, b};
        w_res = w_sum[31:0];
        w_c   = w_sum[32];
        w_v   = (a[31] == b[31]) && (w_sum[31] != a[31]);
      end
      4'h7: begin
        w_sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        w_res = w_sum[31:0];
        w_c   = w_sum[32];
        w_v   = (a[31] != b[31]) && (w_sum[31] != a[31]);
      end
`ifdef ALU_SHIFT_EN
      4'h8: begin
        w_res = w_lsl[31:0];
        w_c   = w_lsl[32];
      end
      4'h9: begin
        w_res = w_lsr[32:1];
        w_c   = w_lsr[0];
      end
      4'hA: begin
        w_res = w_asr[32:1];
        w_c   = w_asr[0];
      end
      4'hB: begin
        w_res = w_ror;
        w_c   = (w_amt != 5'd0) && w_ror[31];
      end
`endif
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ALU_result <= '0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b1;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
    end else begin
      ALU_result <= w_res;
      flag_n     <= w_res[31];
      flag_z     <= (w_res == 32'h0);
      flag_c     <= w_c;
      flag_v     <= w_v;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed scoreboard bench for alu; expected results queued at drive time.
// Shift expectations follow ALU_SHIFT_EN the same way the design does.
module tb_alu;

  logic        clk;
  logic        reset_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic [31:0] ALU_result;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;

  alu dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .a          (a),
    .b          (b),
    .op         (op),
    .ALU_result (ALU_result),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .flag_v     (flag_v)
  );

  typedef struct {
    logic [31:0] r;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check();
    exp_t e;
    logic [35:0] got;
    logic [35:0] want;
    total++;
    if (q.size() == 0) begin
      $error("FAIL scoreboard_empty got=none exp=entry");
      return;
    end
    e    = q.pop_front();
    got  = {ALU_result, flag_n, flag_z, flag_c, flag_v};
    want = {e.r, e.n, e.z, e.c, e.v};
    assert (got === want) passed++;
    else $error("FAIL %s got r=%h nzcv=%b exp r=%h nzcv=%b",
                e.tag, got[35:4], got[3:0], want[35:4], want[3:0]);
  endtask

  task automatic drive(input logic rn, input logic [3:0] o,
                       input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] er, input logic ec,
                       input logic ev, input string t);
    exp_t e;
    reset_n = rn;
    op      = o;
    a       = ia;
    b       = ib;
    e.r   = er;
    e.n   = er[31];
    e.z   = (er == 32'h0);
    e.c   = ec;
    e.v   = ev;
    e.tag = t;
    q.push_back(e);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    reset_n = 1'b0;
    op = 4'h6;
    a  = 32'hFFFFFFFF;
    b  = 32'h1;
    drive(0, 4'h6, 32'hFFFFFFFF, 1, 32'h0, 0, 0, "reset0");
    drive(0, 4'h6, 32'hFFFFFFFF, 1, 32'h0, 0, 0, "reset1");
    drive(1, 4'h6, 32'hFFFFFFFF, 1, 32'h0, 1, 0, "rel_add");

    drive(1, 4'h1, 3, 0, 32'hFFFFFFFC, 0, 0, "not");
    drive(1, 4'h2, 5, 9, 32'h1, 0, 0, "and");
    drive(1, 4'h3, 5, 32'hA, 32'hF, 0, 0, "or");
    drive(1, 4'h4, 3, 5, 32'h6, 0, 0, "xor");
    drive(1, 4'h5, 3, 5, 32'hFFFFFFF9, 0, 0, "xnor");
    drive(1, 4'h0, 3, 5, 32'h0, 0, 0, "nop");

    drive(1, 4'h6, 0, 0, 32'h0, 0, 0, "add0");
    drive(1, 4'h6, 32'hFFFFFFFF, 32'hF, 32'hE, 1, 0, "add_c");
    drive(1, 4'h6, 32'hA, 3, 32'hD, 0, 0, "add");
    drive(1, 4'h6, 32'h7FFFFFFF, 1, 32'h80000000, 0, 1, "add_v");

    drive(1, 4'h7, 32'hF, 5, 32'hA, 1, 0, "sub");
    drive(1, 4'h7, 5, 7, 32'hFFFFFFFE, 0, 0, "sub_b");
    drive(1, 4'h7, 32'hA, 32'hA, 32'h0, 1, 0, "sub_z");
    drive(1, 4'h7, 32'h80000000, 1, 32'h7FFFFFFF, 1, 1, "sub_v");

`ifdef ALU_SHIFT_EN
    drive(1, 4'h8, 32'h80000001, 1, 32'h2, 1, 0, "lsl");
    drive(1, 4'h9, 32'h80000001, 1, 32'h40000000, 1, 0, "lsr");
    drive(1, 4'hA, 32'h80000001, 1, 32'hC0000000, 1, 0, "asr");
    drive(1, 4'hB, 32'h80000001, 1, 32'hC0000000, 1, 0, "ror");
    drive(1, 4'h8, 32'h80000001, 32, 32'h80000001, 0, 0, "lsl32");
    drive(1, 4'hA, 32'h80000001, 32, 32'h80000001, 0, 0, "asr32");
    drive(1, 4'h9, 32'h80000001, 32'h21, 32'h40000000, 1, 0, "lsr_hi");
    drive(1, 4'hB, 1, 4, 32'h10000000, 0, 0, "ror4");
    drive(1, 4'h8, 32'h40000000, 2, 32'h0, 1, 0, "lsl_z");
    drive(1, 4'hA, 32'h70000000, 4, 32'h07000000, 0, 0, "asr_pos");
`else
    drive(1, 4'h8, 32'h80000001, 1, 32'h0, 0, 0, "lsl_off");
    drive(1, 4'h9, 32'h80000001, 1, 32'h0, 0, 0, "lsr_off");
    drive(1, 4'hA, 32'h80000001, 1, 32'h0, 0, 0, "asr_off");
    drive(1, 4'hB, 32'h80000001, 1, 32'h0, 0, 0, "ror_off");
`endif

    drive(1, 4'h0, 3, 5, 32'h0, 0, 0, "b2b0");
    drive(1, 4'h1, 3, 5, 32'hFFFFFFFC, 0, 0, "b2b1");
    drive(1, 4'h2, 3, 5, 32'h1, 0, 0, "b2b2");
    drive(1, 4'h3, 3, 5, 32'h7, 0, 0, "b2b3");
    drive(1, 4'h4, 3, 5, 32'h6, 0, 0, "b2b4");
    drive(1, 4'h5, 3, 5, 32'hFFFFFFF9, 0, 0, "b2b5");
    drive(1, 4'h6, 3, 5, 32'h8, 0, 0, "b2b6");
    drive(1, 4'h7, 3, 5, 32'hFFFFFFFE, 0, 0, "b2b7");
    drive(1, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 0, "rsvF");
    drive(1, 4'hC, 32'h7FFFFFFF, 1, 32'h0, 0, 0, "rsvC");

    drive(1, 4'h6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0, "pre_rst");
    drive(0, 4'h1, 0, 0, 32'h0, 0, 0, "mid_rst");
    drive(1, 4'h1, 0, 0, 32'hFFFFFFFF, 0, 0, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
